split_packer: RTL

Downstream neighbour of the MFK frame reader. After the reader signals a complete 48-word frame (`RXdone`), this block pulls the words one at a time over the `reqSPLIT`/`TXen` handshake. It splits each 18-bit word into three tagged 6-bit bytes and hands them to the byte transmitter over a valid/ack interface. It sits between the reader's `dout` port and the serial output stage.

---
 rtl/split_packer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/split_packer.sv
// Splits 18-bit reader words into three tagged 6-bit bytes on a valid/ack stream.
// Define SPLIT_HEADER_EN to prefix each frame with a {2'b11, frame_cnt} header byte.
module split_packer #(
  parameter int unsigned WORDS = 48,
  parameter int unsigned GUARD = 4
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        RXdone,
  input  logic [17:0] din,
  input  logic        TXen,
  output logic        reqSPLIT,
  output logic [7:0]  byteOut,
  output logic        byteValid,
  input  logic        byteAck,
  output logic        frameDone,
  output logic        busy
);

  localparam int unsigned GW = $clog2(GUARD + 1);
  localparam logic [5:0]    WordsL = 6'(WORDS);
  localparam logic [GW-1:0] GuardLast = GW'(GUARD - 1);

  typedef enum logic [2:0] {StIdle, StHdr, StReq, StWait, StSend, StGuard} state_t;

  state_t        state;
  logic          txen_q;
  logic [11:0]   word_q;  // byte 0 comes straight from din, so only the low fields are kept
  logic [5:0]    cnt;
  logic [GW-1:0] guard_cnt;
`ifdef SPLIT_HEADER_EN
  logic [5:0]    frame_cnt;
`endif

  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= StIdle;
      txen_q    <= 1'b0;
      word_q    <= '0;
      cnt       <= '0;
      guard_cnt <= '0;
      reqSPLIT  <= 1'b0;
      byteOut   <= '0;
      byteValid <= 1'b0;
      frameDone <= 1'b0;
      busy      <= 1'b0;
`ifdef SPLIT_HEADER_EN
      frame_cnt <= '0;
`endif
    end else begin
      txen_q    <= TXen;
      frameDone <= 1'b0;
      unique case (state)
        StIdle: begin
          if (RXdone) begin
            busy <= 1'b1;
`ifdef SPLIT_HEADER_EN
            byteOut   <= {2'b11, frame_cnt};
            byteValid <= 1'b1;
            state     <= StHdr;
`else
            reqSPLIT <= 1'b1;
            state    <= StReq;
`endif
          end
        end
        StHdr: begin
          if (byteAck) begin
            byteValid <= 1'b0;
            reqSPLIT  <= 1'b1;
            state     <= StReq;
          end
        end
        StReq: begin
          if (TXen && !txen_q) begin
            word_q    <= din[11:0];
            reqSPLIT  <= 1'b0;
            byteOut   <= {2'b00, din[17:12]};
            byteValid <= 1'b1;
            state     <= StWait;
          end
        end
        StWait: begin
          if (byteAck) begin
            byteOut <= {2'b01, word_q[11:6]};
            state   <= StSend;
          end
        end
        StSend: begin
          if (byteAck) begin
            if (byteOut[7:6] == 2'b01) begin
              byteOut <= {2'b10, word_q[5:0]};
            end else begin
              byteValid <= 1'b0;
              cnt       <= cnt + 6'd1;
              guard_cnt <= '0;
              state     <= StGuard;
            end
          end
        end
        StGuard: begin
          // Counting starts only once TXen has been seen low; later TXen activity is ignored.
          if (!(guard_cnt == '0 && TXen)) begin
            if (guard_cnt == GuardLast) begin
              guard_cnt <= '0;
              if (cnt == WordsL) begin
                cnt       <= '0;
                frameDone <= 1'b1;
                busy      <= 1'b0;
                state     <= StIdle;
`ifdef SPLIT_HEADER_EN
                frame_cnt <= frame_cnt + 6'd1;
`endif
              end else begin
                reqSPLIT <= 1'b1;
                state    <= StReq;
              end
            end else begin
              guard_cnt <= guard_cnt + 1'b1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
